// File: rtl/wb_flash_arbiter_if.sv
// Pipelined Wishbone bus bundle used between the flash arbiter, its two
// masters and the spi flash controller's data port.
//   cyc/stb/we/addr/dat_w/sel : master -> slave request
//   stall/ack/dat_r           : slave -> master response
// Modports: master (drives the request), slave (drives the response).
interface wb_flash_arbiter_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            stall;
  logic            ack;
  logic [DW-1:0]   dat_r;

  modport master (output cyc, stb, we, addr, dat_w, sel,
                  input  stall, ack, dat_r);
  modport slave  (input  cyc, stb, we, addr, dat_w, sel,
                  output stall, ack, dat_r);
endinterface

// File: rtl/wb_flash_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the spi flash data port.
// Master A = instruction fetch, master B = load/store path. The owner keeps
// the bus for its whole cyc; contention is resolved round-robin.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   a_wb, b_wb     : master A / B buses (slave modport)
//   wb             : bus to the spi controller (master modport)
//   o_grant        : {B,A} one-hot current owner, 00 when idle
//   o_timeout      : 1-cycle pulse on watchdog abort
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the ownership
// watchdog (TIMEOUT_CYCLES owned cycles without an ack aborts the cycle).
module wb_flash_arbiter #(
  parameter int AW             = 22,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_flash_arbiter_if.slave    a_wb,
  wb_flash_arbiter_if.slave    b_wb,
  wb_flash_arbiter_if.master   wb,
  output logic [1:0]           o_grant,
  output logic                 o_timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_flash_arbiter: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state;
  logic   prio_b;   // 1: B wins the next tie
  logic   tmo;      // watchdog abort this cycle

  wire own_a = (state == OWN_A);
  wire own_b = (state == OWN_B);

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Counts owned cycles; an ack restarts the window. IDLE holds it at zero,
  // so the first owned cycle after a grant sees 0.
  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE || wb.ack)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

  // Decoded purely from registers, so the pulse is glitch-free.
  assign tmo       = (state != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign o_timeout = tmo;
`else
  assign tmo       = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      prio_b  <= 1'b0;
      o_grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (a_wb.cyc && (!b_wb.cyc || !prio_b)) begin
            state   <= OWN_A;
            o_grant <= 2'b01;
          end else if (b_wb.cyc) begin
            state   <= OWN_B;
            o_grant <= 2'b10;
          end
        end
        OWN_A: begin
          if (!a_wb.cyc || tmo) begin
            state   <= IDLE;
            prio_b  <= 1'b1;
            o_grant <= 2'b00;
          end
        end
        OWN_B: begin
          if (!b_wb.cyc || tmo) begin
            state   <= IDLE;
            prio_b  <= 1'b0;
            o_grant <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

  // Request path: owner's signals pass straight through; a watchdog abort
  // drops cyc/stb in the abort cycle itself.
  always_comb begin
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    wb.we    = 1'b0;
    wb.addr  = '0;
    wb.dat_w = '0;
    wb.sel   = '0;
    if (own_a) begin
      wb.cyc   = a_wb.cyc & ~tmo;
      wb.stb   = a_wb.stb & ~tmo;
      wb.we    = a_wb.we;
      wb.addr  = a_wb.addr;
      wb.dat_w = a_wb.dat_w;
      wb.sel   = a_wb.sel;
    end else if (own_b) begin
      wb.cyc   = b_wb.cyc & ~tmo;
      wb.stb   = b_wb.stb & ~tmo;
      wb.we    = b_wb.we;
      wb.addr  = b_wb.addr;
      wb.dat_w = b_wb.dat_w;
      wb.sel   = b_wb.sel;
    end
  end

  // Response path: non-owners are stalled with no ack and zero data, so
  // late acks after a release are simply dropped.
  assign a_wb.stall = own_a ? (wb.stall | tmo) : 1'b1;
  assign a_wb.ack   = own_a & wb.ack & ~tmo;
  assign a_wb.dat_r = own_a ? wb.dat_r : '0;

  assign b_wb.stall = own_b ? (wb.stall | tmo) : 1'b1;
  assign b_wb.ack   = own_b & wb.ack & ~tmo;
  assign b_wb.dat_r = own_b ? wb.dat_r : '0;

endmodule

// File: tb/tb_wb_flash_arbiter.sv
module tb_wb_flash_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo_o;
  int         total = 0;
  int         bad   = 0;

  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) b_if ();
  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  wb_flash_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .a_wb      (a_if),
    .b_wb      (b_if),
    .wb        (s_if),
    .o_grant   (grant),
    .o_timeout (tmo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    a_if.cyc = 0; a_if.stb = 0; a_if.we = 0; a_if.addr = '0; a_if.dat_w = '0; a_if.sel = '0;
    b_if.cyc = 0; b_if.stb = 0; b_if.we = 0; b_if.addr = '0; b_if.dat_w = '0; b_if.sel = '0;
    s_if.stall = 0; s_if.ack = 0; s_if.dat_r = '0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc, acks, bviol, drops, tos;
    logic pend;
    rst = 1'b1;
    clr_inputs();
    do_reset();

    // reset state
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_tmo", 64'(tmo_o), 64'd0);
    chk("rst_cyc", 64'(s_if.cyc), 64'd0);
    chk("rst_a_stall", 64'(a_if.stall), 64'd1);
    chk("rst_b_ack", 64'(b_if.ack), 64'd0);

    // 1: A single read of 0x000010
    a_if.cyc = 1; a_if.stb = 1; a_if.sel = 4'hF; a_if.addr = 22'h000010;
    #1;
    chk("t1_idle_cyc", 64'(s_if.cyc), 64'd0);
    chk("t1_idle_stall", 64'(a_if.stall), 64'd1);
    tick();
    chk("t1_grant", 64'(grant), 64'd1);
    chk("t1_addr", 64'(s_if.addr), 64'h10);
    chk("t1_stb", 64'(s_if.stb), 64'd1);
    chk("t1_a_stall", 64'(a_if.stall), 64'd0);
    tick();
    a_if.stb = 0; s_if.ack = 1; s_if.dat_r = 32'hDEADBEEF;
    #1;
    chk("t1_a_ack", 64'(a_if.ack), 64'd1);
    chk("t1_a_data", 64'(a_if.dat_r), 64'hDEADBEEF);
    chk("t1_b_ack", 64'(b_if.ack), 64'd0);
    chk("t1_b_data", 64'(b_if.dat_r), 64'd0);
    tick();
    s_if.ack = 0; a_if.cyc = 0;
    #1;
    chk("t1_release_cyc", 64'(s_if.cyc), 64'd0);
    tick();
    chk("t1_idle_grant", 64'(grant), 64'd0);

    // 2: simultaneous request after reset -> A, then B
    do_reset();
    a_if.cyc = 1; b_if.cyc = 1;
    tick();
    chk("t2_grant_a", 64'(grant), 64'd1);
    chk("t2_b_stall", 64'(b_if.stall), 64'd1);
    a_if.cyc = 0;
    #1;
    chk("t2_rel_cyc", 64'(s_if.cyc), 64'd0);
    tick();
    chk("t2_idle", 64'(grant), 64'd0);
    tick();
    chk("t2_grant_b", 64'(grant), 64'd2);
    chk("t2_b_cyc", 64'(s_if.cyc), 64'd1);
    b_if.cyc = 0;
    tick(); // IDLE, pointer back at A

    // 3: A four pipelined strobes, slave stalls 2 cycles each, B waiting
    a_if.cyc = 1; a_if.stb = 1; b_if.cyc = 1;
    tick();
    chk("t3_grant", 64'(grant), 64'd1);
    acc = 0; acks = 0; bviol = 0; pend = 0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        a_if.addr = 22'(32'h100 + i);
        s_if.stall = (c < 2);
        s_if.ack = pend;
        s_if.dat_r = 32'(i);
        #1;
        if (a_if.stb && !a_if.stall && s_if.addr == 22'(32'h100 + i)) acc++;
        if (a_if.ack) acks++;
        if (b_if.stall !== 1'b1 || b_if.ack !== 1'b0) bviol++;
        pend = (c == 2);
        tick();
      end
    end
    a_if.stb = 0; s_if.stall = 0; s_if.ack = pend;
    #1;
    if (a_if.ack) acks++;
    tick();
    chk("t3_accepted", 64'(acc), 64'd4);
    chk("t3_acks", 64'(acks), 64'd4);
    chk("t3_b_blocked", 64'(bviol), 64'd0);
    s_if.ack = 0; a_if.cyc = 0;
    tick(); // IDLE, pointer now B
    tick();
    chk("t4_b_owns", 64'(grant), 64'd2);

    // 4: B owns, A waits; B drops and re-raises -> A first
    a_if.cyc = 1;
    tick();
    chk("t4_b_held", 64'(grant), 64'd2);
    b_if.cyc = 0;
    tick();
    chk("t4_idle", 64'(grant), 64'd0);
    b_if.cyc = 1;
    tick();
    chk("t4_a_wins", 64'(grant), 64'd1);
    a_if.cyc = 0;
    tick();
    tick();
    chk("t5_b_owns", 64'(grant), 64'd2);

    // 5: reset during a B write
    b_if.stb = 1; b_if.we = 1; b_if.addr = 22'h2AAAA; b_if.dat_w = 32'hCAFE0001; b_if.sel = 4'h3;
    #1;
    chk("t5_we", 64'(s_if.we), 64'd1);
    chk("t5_wdata", 64'(s_if.dat_w), 64'hCAFE0001);
    chk("t5_sel", 64'(s_if.sel), 64'h3);
    rst = 1; s_if.ack = 1;
    tick();
    chk("t5_cyc", 64'(s_if.cyc), 64'd0);
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_b_ack", 64'(b_if.ack), 64'd0);
    do_reset();

    // 6: slave never acks
    a_if.cyc = 1; a_if.stb = 1;
    tick();
    chk("t6_grant", 64'(grant), 64'd1);
    a_if.stb = 0;
`ifdef WB_ARB_TIMEOUT_EN
    tos = 0;
    for (int k = 1; k < TMO; k++) begin
      #1;
      if (tmo_o) tos++;
      tick();
    end
    chk("t6_early_tmo", 64'(tos), 64'd0);
    s_if.ack = 1;
    #1;
    chk("t6_tmo", 64'(tmo_o), 64'd1);
    chk("t6_cyc_drop", 64'(s_if.cyc), 64'd0);
    chk("t6_ack_supp", 64'(a_if.ack), 64'd0);
    tick();
    s_if.ack = 0;
    chk("t6_tmo_end", 64'(tmo_o), 64'd0);
    chk("t6_idle", 64'(grant), 64'd0);
`else
    drops = 0; tos = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!s_if.cyc) drops++;
      if (tmo_o) tos++;
      tick();
    end
    chk("t6_cyc_held", 64'(drops), 64'd0);
    chk("t6_no_tmo", 64'(tos), 64'd0);
    chk("t6_grant_held", 64'(grant), 64'd1);
`endif
    clr_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end
endmodule
